// File: rtl/conv1_window_gen.sv
// Raster-to-window feeder for the first convolution stage: 2-wide x 5-tall windows,
// stride 1 in x and STRIDEY in y, built from a 4-row line buffer plus a column register.
module conv1_window_gen #(
    parameter int WORDLENGTH = 16,
    parameter int WIDTH      = 166,
    parameter int HEIGHT     = 586,
    parameter int STRIDEY    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic signed [WORDLENGTH-1:0] pixel_in,
    input  logic                         pixel_valid,
    output logic signed [WORDLENGTH-1:0] window1,
    output logic signed [WORDLENGTH-1:0] window2,
    output logic signed [WORDLENGTH-1:0] window3,
    output logic signed [WORDLENGTH-1:0] window4,
    output logic signed [WORDLENGTH-1:0] window5,
    output logic signed [WORDLENGTH-1:0] window6,
    output logic signed [WORDLENGTH-1:0] window7,
    output logic signed [WORDLENGTH-1:0] window8,
    output logic signed [WORDLENGTH-1:0] window9,
    output logic signed [WORDLENGTH-1:0] window10,
    output logic                         window_valid,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    state_t                state_next;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic [1:0]            row_ptr;
    logic [WORDLENGTH-1:0] line_buf [4][WIDTH];
    logic [WORDLENGTH-1:0] col_reg  [5];
    logic [WORDLENGTH-1:0] col_now  [5];
    logic [WORDLENGTH-1:0] win      [10];
    logic                  accept;
    logic                  x_last;
    logic                  y_last;
    logic                  trigger;

    // row_ptr holds the oldest stored row (y-4); the following slots hold y-3..y-1
    always_comb begin
        accept  = pixel_valid && !clear;
        x_last  = (x_cnt == XW'(WIDTH - 1));
        y_last  = (y_cnt == YW'(HEIGHT - 1));
        trigger = accept && (x_cnt != '0) && (y_cnt >= YW'(4)) &&
                  ((STRIDEY == 1) || !y_cnt[0]);
        for (int unsigned k = 0; k < 4; k++) begin
            col_now[k] = line_buf[row_ptr + 2'(k)][x_cnt];
        end
        col_now[4] = pixel_in;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = (x_last && y_last) ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            row_ptr <= '0;
        end else if (clear) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            row_ptr <= '0;
        end else if (accept) begin
            if (x_last) begin
                x_cnt <= '0;
                if (y_last) begin
                    y_cnt   <= '0;
                    row_ptr <= '0;
                end else begin
                    y_cnt   <= y_cnt + 1'b1;
                    row_ptr <= row_ptr + 1'b1;
                end
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Read-before-write: col_now sampled the old contents of this slot
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[row_ptr][x_cnt] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            for (int unsigned k = 0; k < 5; k++) begin
                col_reg[k] <= '0;
            end
            for (int unsigned k = 0; k < 10; k++) begin
                win[k] <= '0;
            end
        end else begin
            window_valid <= trigger;
            frame_done   <= accept && x_last && y_last;
            if (accept) begin
                for (int unsigned k = 0; k < 5; k++) begin
                    col_reg[k] <= col_now[k];
                end
            end
            if (trigger) begin
                for (int unsigned k = 0; k < 5; k++) begin
                    win[k]     <= col_reg[k];
                    win[k + 5] <= col_now[k];
                end
            end
        end
    end

    assign busy     = (state == ACTIVE);
    assign window1  = win[0];
    assign window2  = win[1];
    assign window3  = win[2];
    assign window4  = win[3];
    assign window5  = win[4];
    assign window6  = win[5];
    assign window7  = win[6];
    assign window8  = win[7];
    assign window9  = win[8];
    assign window10 = win[9];

endmodule

// File: tb/tb_conv1_window_gen.sv
// Directed bench for conv1_window_gen on a 4x7 frame; a STRIDEY=2 and a STRIDEY=1 instance share stimulus.
module tb_conv1_window_gen;

    localparam int W = 4;
    localparam int H = 7;

    typedef struct packed {
        logic [9:0][15:0] w;
        int               f;
        int               y;
        int               x;
    } strobe_t;

    typedef struct packed {
        int f;
        int y;
        int x;
    } tag_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic [15:0] wa [10];
    logic [15:0] wb [10];
    logic        va, vb, fda, fdb, busya, busyb;

    int n_checks = 0;
    int n_fail   = 0;
    int px = -1, py = -1, pf = -1;

    strobe_t sa[$];
    strobe_t sb[$];
    strobe_t exp_a[$];
    strobe_t exp_b[$];
    tag_t    fd_q[$];

    always #5 clk = ~clk;

    conv1_window_gen #(.WORDLENGTH(16), .WIDTH(W), .HEIGHT(H), .STRIDEY(2)) dut (
        .clk(clk), .reset(reset), .clear(clear), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .window1(wa[0]), .window2(wa[1]), .window3(wa[2]), .window4(wa[3]), .window5(wa[4]),
        .window6(wa[5]), .window7(wa[6]), .window8(wa[7]), .window9(wa[8]), .window10(wa[9]),
        .window_valid(va), .frame_done(fda), .busy(busya)
    );

    conv1_window_gen #(.WORDLENGTH(16), .WIDTH(W), .HEIGHT(H), .STRIDEY(1)) dut_s1 (
        .clk(clk), .reset(reset), .clear(clear), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .window1(wb[0]), .window2(wb[1]), .window3(wb[2]), .window4(wb[3]), .window5(wb[4]),
        .window6(wb[5]), .window7(wb[6]), .window8(wb[7]), .window9(wb[8]), .window10(wb[9]),
        .window_valid(vb), .frame_done(fdb), .busy(busyb)
    );

    function automatic logic [15:0] val(input int x, input int y, input int base, input bit neg);
        int v;
        v = base + y * 16 + x;
        return neg ? 16'(-v) : 16'(v);
    endfunction

    // One cycle: log what the previous cycle's sample produced, then drive the next one.
    task automatic step(input logic v, input logic [15:0] d, input logic clr,
                        input int tx, input int ty, input int tf);
        strobe_t s;
        tag_t    t;
        @(negedge clk);
        if (va) begin
            for (int k = 0; k < 10; k++) s.w[k] = wa[k];
            s.x = px; s.y = py; s.f = pf;
            sa.push_back(s);
        end
        if (vb) begin
            for (int k = 0; k < 10; k++) s.w[k] = wb[k];
            s.x = px; s.y = py; s.f = pf;
            sb.push_back(s);
        end
        if (fda) begin
            t.x = px; t.y = py; t.f = pf;
            fd_q.push_back(t);
        end
        pixel_valid = v;
        pixel_in    = d;
        clear       = clr;
        if (v && !clr) begin
            px = tx; py = ty; pf = tf;
        end else begin
            px = -1; py = -1; pf = -1;
        end
    endtask

    task automatic send_frame(input int f, input int base, input bit neg, input bit gaps,
                              input int stop_at, input bit do_clear);
        for (int i = 0; i < W * H; i++) begin
            automatic int x = i % W;
            automatic int y = i / W;
            automatic int ng = 0;
            while (gaps && ng < 4 && $urandom_range(0, 1) == 1) begin
                step(1'b0, 16'($urandom), 1'b0, -1, -1, -1);
                ng++;
            end
            if (do_clear && i == stop_at) begin
                step(1'b1, val(x, y, base, neg), 1'b1, -1, -1, -1);
                return;
            end
            step(1'b1, val(x, y, base, neg), 1'b0, x, y, f);
            if (!do_clear && i == stop_at) return;
        end
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 16'h0, 1'b0, -1, -1, -1);
    endtask

    task automatic clear_logs();
        sa.delete(); sb.delete(); exp_a.delete(); exp_b.delete(); fd_q.delete();
    endtask

    // Expected strobes: one per trigger sample (x,y); window top-left is (x-1, y-4).
    task automatic add_expected(input int f, input int base, input bit neg);
        strobe_t s;
        for (int y = 4; y < H; y++) begin
            for (int x = 1; x < W; x++) begin
                s.x = x; s.y = y; s.f = f;
                for (int k = 0; k < 5; k++) begin
                    s.w[k]     = val(x - 1, y - 4 + k, base, neg);
                    s.w[k + 5] = val(x, y - 4 + k, base, neg);
                end
                exp_b.push_back(s);
                if ((y - 4) % 2 == 0) exp_a.push_back(s);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (va !== 1'b0 || fda !== 1'b0 || busya !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b done=%b busy=%b, want 0 0 0", va, fda, busya);
        end
        n_checks++;
        if (wa[0] !== 16'h0 || wa[9] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_words: got w1=%h w10=%h, want 0000 0000", wa[0], wa[9]);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [9:0][15:0] c;
        clear_logs();
        send_frame(1, 0, 1'b0, 1'b0, -1, 1'b0);
        drain();
        add_expected(1, 0, 1'b0);
        n_checks++;
        if (sa.size() != 6) begin
            n_fail++; $display("FAIL basic_count: got %0d strobes, want 6", sa.size());
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL basic_win[%0d]: got x=%0d y=%0d w=%h, want x=%0d y=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].w);
            end
        end
        c = '0;
        c[0] = 16'd0;  c[1] = 16'd16; c[2] = 16'd32; c[3] = 16'd48; c[4] = 16'd64;
        c[5] = 16'd1;  c[6] = 16'd17; c[7] = 16'd33; c[8] = 16'd49; c[9] = 16'd65;
        if (sa.size() >= 1) begin
            n_checks++;
            if (sa[0].w !== c || sa[0].x != 1 || sa[0].y != 4) begin
                n_fail++; $display("FAIL basic_first: got x=%0d y=%0d w=%h, want x=1 y=4 w=%h",
                                   sa[0].x, sa[0].y, sa[0].w, c);
            end
        end
        if (sa.size() >= 4) begin
            n_checks++;
            if (sa[3].w[0] !== 16'd32 || sa[3].w[1] !== 16'd48 || sa[3].w[2] !== 16'd64 ||
                sa[3].w[3] !== 16'd80 || sa[3].w[4] !== 16'd96) begin
                n_fail++; $display("FAIL basic_fourth: got w1..5=%0d %0d %0d %0d %0d, want 32 48 64 80 96",
                                   sa[3].w[0], sa[3].w[1], sa[3].w[2], sa[3].w[3], sa[3].w[4]);
            end
        end
        n_checks++;
        if (fd_q.size() != 1 || fd_q[0].x != 3 || fd_q[0].y != 6) begin
            n_fail++; $display("FAIL basic_frame_done: got %0d pulses, want 1 after sample (3,6)", fd_q.size());
        end
    endtask

    task automatic test_stride1();
        clear_logs();
        send_frame(2, 0, 1'b0, 1'b0, -1, 1'b0);
        drain();
        add_expected(2, 0, 1'b0);
        n_checks++;
        if (sb.size() != 9) begin
            n_fail++; $display("FAIL stride1_count: got %0d strobes, want 9", sb.size());
        end
        for (int i = 0; i < sb.size() && i < exp_b.size(); i++) begin
            n_checks++;
            if (sb[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL stride1_win[%0d]: got x=%0d y=%0d w=%h, want x=%0d y=%0d w=%h",
                         i, sb[i].x, sb[i].y, sb[i].w, exp_b[i].x, exp_b[i].y, exp_b[i].w);
            end
        end
        if (sb.size() >= 4) begin
            n_checks++;
            if (sb[3].x != 1 || sb[3].y != 5 || sb[3].w[0] !== 16'd16 || sb[3].w[4] !== 16'd80 ||
                sb[3].w[5] !== 16'd17 || sb[3].w[9] !== 16'd81) begin
                n_fail++; $display("FAIL stride1_y5: got x=%0d y=%0d w=%h, want x=1 y=5 w1=16 w5=80 w6=17 w10=81",
                                   sb[3].x, sb[3].y, sb[3].w);
            end
        end
    endtask

    task automatic test_gapped();
        clear_logs();
        send_frame(3, 0, 1'b0, 1'b1, -1, 1'b0);
        drain();
        add_expected(3, 0, 1'b0);
        n_checks++;
        if (sa.size() != exp_a.size()) begin
            n_fail++; $display("FAIL gapped_count: got %0d strobes, want %0d", sa.size(), exp_a.size());
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL gapped_win[%0d]: got x=%0d y=%0d f=%0d w=%h, want x=%0d y=%0d f=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].f, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].f, exp_a[i].w);
            end
        end
        n_checks++;
        if (fd_q.size() != 1) begin
            n_fail++; $display("FAIL gapped_frame_done: got %0d pulses, want 1", fd_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(4, 0, 1'b0, 1'b0, -1, 1'b0);
        send_frame(5, 256, 1'b0, 1'b0, -1, 1'b0);
        drain();
        add_expected(4, 0, 1'b0);
        add_expected(5, 256, 1'b0);
        n_checks++;
        if (sa.size() != 12) begin
            n_fail++; $display("FAIL b2b_count: got %0d strobes, want 12", sa.size());
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL b2b_win[%0d]: got x=%0d y=%0d f=%0d w=%h, want x=%0d y=%0d f=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].f, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].f, exp_a[i].w);
            end
        end
        n_checks++;
        if (fd_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_frame_done: got %0d pulses, want 2", fd_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send_frame(6, 0, 1'b0, 1'b0, 20, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pixel_valid = 1'b0;
        #1;
        n_checks++;
        if (va !== 1'b0 || fda !== 1'b0 || busya !== 1'b0 || wa[0] !== 16'h0 || wa[9] !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b done=%b busy=%b w1=%h w10=%h, want all 0",
                     va, fda, busya, wa[0], wa[9]);
        end
        px = -1; py = -1; pf = -1;
        drain();
        reset = 1'b1;
        clear_logs();
        send_frame(7, 0, 1'b0, 1'b0, -1, 1'b0);
        drain();
        add_expected(7, 0, 1'b0);
        n_checks++;
        if (sa.size() != 6) begin
            n_fail++; $display("FAIL midreset_count: got %0d strobes, want 6", sa.size());
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL midreset_win[%0d]: got x=%0d y=%0d w=%h, want x=%0d y=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].w);
            end
        end
    endtask

    task automatic test_clear_mid_frame();
        clear_logs();
        send_frame(8, 0, 1'b0, 1'b0, 10, 1'b1);
        n_checks++;
        if (busya !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy_before: got %b, want 1", busya);
        end
        step(1'b0, 16'h0, 1'b0, -1, -1, -1);
        n_checks++;
        if (busya !== 1'b0) begin
            n_fail++; $display("FAIL clear_busy_after: got %b, want 0", busya);
        end
        drain();
        n_checks++;
        if (sa.size() != 0 || fd_q.size() != 0) begin
            n_fail++; $display("FAIL clear_aborted: got %0d strobes %0d frame_done, want 0 0", sa.size(), fd_q.size());
        end
        send_frame(9, 0, 1'b0, 1'b0, -1, 1'b0);
        drain();
        add_expected(9, 0, 1'b0);
        n_checks++;
        if (sa.size() != 6 || fd_q.size() != 1) begin
            n_fail++; $display("FAIL clear_next_count: got %0d strobes %0d frame_done, want 6 1", sa.size(), fd_q.size());
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL clear_next_win[%0d]: got x=%0d y=%0d w=%h, want x=%0d y=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].w);
            end
        end
    endtask

    task automatic test_negative();
        clear_logs();
        send_frame(10, 0, 1'b1, 1'b0, -1, 1'b0);
        drain();
        add_expected(10, 0, 1'b1);
        n_checks++;
        if (sa.size() != 6) begin
            n_fail++; $display("FAIL neg_count: got %0d strobes, want 6", sa.size());
        end
        if (sa.size() >= 1) begin
            n_checks++;
            if (sa[0].w[0] !== 16'h0000 || sa[0].w[1] !== 16'hFFF0) begin
                n_fail++; $display("FAIL neg_first: got w1=%h w2=%h, want 0000 fff0", sa[0].w[0], sa[0].w[1]);
            end
        end
        for (int i = 0; i < sa.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (sa[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL neg_win[%0d]: got x=%0d y=%0d w=%h, want x=%0d y=%0d w=%h",
                         i, sa[i].x, sa[i].y, sa[i].w, exp_a[i].x, exp_a[i].y, exp_a[i].w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stride1();
        test_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        test_clear_mid_frame();
        test_negative();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
